// File: rtl/jk_bank_driver.sv
// jk_bank_driver: turns requested target words for an external JK flip-flop
// bank into one-cycle J/K excitation pulses, then checks the bank's q feedback.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | j=k=0, ready for a target; done pulses here after a CHECK
// DRIVE | j/k hold the registered excitation for exactly one cycle
// CHECK | j=k=0, compare q_fb against the target, update status
module jk_bank_driver #(
    parameter int WIDTH   = 4,
    parameter int DC_MODE = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tgt_valid,
    input  logic [WIDTH-1:0] tgt_data,
    output logic             tgt_ready,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k,
    input  logic [WIDTH-1:0] q_fb,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] err_mask,
    output logic [7:0]       xfer_count
);

    typedef enum logic [1:0] {IDLE, DRIVE, CHECK} state_t;

    // Don't-care resolution: with DC_MODE set, every changing bit toggles (J=K=1).
    localparam logic [WIDTH-1:0] DC_VEC = (DC_MODE != 0) ? '1 : '0;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] model_q, model_d;
    logic [WIDTH-1:0] target_q, target_d;
    logic [WIDTH-1:0] jx_q, jx_d;
    logic [WIDTH-1:0] kx_q, kx_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [7:0]       cnt_q, cnt_d;

    logic [WIDTH-1:0] chg;
    logic [WIDTH-1:0] exc_j;
    logic [WIDTH-1:0] exc_k;

    // Excitation is computed from the internal model, never from q_fb, so unchanged
    // bits always get J=K=0 regardless of DC_MODE.
    assign chg   = model_q ^ tgt_data;
    assign exc_j = (~model_q & tgt_data) | (DC_VEC & chg);
    assign exc_k = (model_q & ~tgt_data) | (DC_VEC & chg);

    assign tgt_ready  = (state_q == IDLE) && reset;
    assign j          = (state_q == DRIVE) ? jx_q : '0;
    assign k          = (state_q == DRIVE) ? kx_q : '0;
    assign done       = done_q;
    assign err        = err_q;
    assign err_mask   = mask_q;
    assign xfer_count = cnt_q;

    // Next-state and datapath updates for the IDLE -> DRIVE -> CHECK sequence.
    always_comb begin
        state_d  = state_q;
        model_d  = model_q;
        target_d = target_q;
        jx_d     = jx_q;
        kx_d     = kx_q;
        done_d   = 1'b0;
        err_d    = err_q;
        mask_d   = mask_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: begin
                if (tgt_valid) begin
                    target_d = tgt_data;
                    jx_d     = exc_j;
                    kx_d     = exc_k;
                    state_d  = DRIVE;
                end
            end
            DRIVE: begin
                state_d = CHECK;
            end
            CHECK: begin
                mask_d  = q_fb ^ target_q;
                err_d   = err_q | (|(q_fb ^ target_q));
                done_d  = 1'b1;
                model_d = target_q;
                cnt_d   = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; synchronous reset abandons any transfer in flight.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            model_q  <= '0;
            target_q <= '0;
            jx_q     <= '0;
            kx_q     <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            mask_q   <= '0;
            cnt_q    <= 8'd0;
        end else begin
            state_q  <= state_d;
            model_q  <= model_d;
            target_q <= target_d;
            jx_q     <= jx_d;
            kx_q     <= kx_d;
            done_q   <= done_d;
            err_q    <= err_d;
            mask_q   <= mask_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: tb/tb_jk_bank_driver.sv
// Bench for jk_bank_driver: two instances (DC_MODE 0 and 1) share stimulus,
// each drives its own behavioural JK bank; expectations come from a scoreboard.
module tb_jk_bank_driver;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         tgt_valid;
    logic [W-1:0] tgt_data;
    logic [W-1:0] stuck;

    logic         rdy0, rdy1, d0, d1, e0, e1;
    logic [W-1:0] j0, k0, j1, k1, q0, q1, fb0, fb1, em0, em1;
    logic [7:0]   c0, c1;

    typedef struct packed {
        logic [W-1:0] tgt;
        logic [W-1:0] j0;
        logic [W-1:0] k0;
        logic [W-1:0] j1;
        logic [W-1:0] k1;
        logic [W-1:0] mask;
        logic         err;
        logic [7:0]   cnt;
    } exp_t;

    exp_t         sb[$];
    logic [W-1:0] m_model;
    logic         m_err;
    logic [7:0]   m_cnt;
    int           n_assert = 0;
    int           n_fail   = 0;

    always #5 clk = ~clk;

    // Behavioural JK banks; the bench clears them with reset so they start at 0
    // like the driver's internal model.
    always @(posedge clk) begin
        if (!reset) begin
            q0 <= '0;
            q1 <= '0;
        end else begin
            q0 <= (j0 & ~q0) | (~k0 & q0);
            q1 <= (j1 & ~q1) | (~k1 & q1);
        end
    end

    assign fb0 = q0 & ~stuck;
    assign fb1 = q1 & ~stuck;

    jk_bank_driver #(.WIDTH(W), .DC_MODE(0)) u_dut0 (
        .clk(clk), .reset(reset), .tgt_valid(tgt_valid), .tgt_data(tgt_data),
        .tgt_ready(rdy0), .j(j0), .k(k0), .q_fb(fb0), .done(d0), .err(e0),
        .err_mask(em0), .xfer_count(c0)
    );

    jk_bank_driver #(.WIDTH(W), .DC_MODE(1)) u_dut1 (
        .clk(clk), .reset(reset), .tgt_valid(tgt_valid), .tgt_data(tgt_data),
        .tgt_ready(rdy1), .j(j1), .k(k1), .q_fb(fb1), .done(d1), .err(e1),
        .err_mask(em1), .xfer_count(c1)
    );

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chk4(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference excitation table and status bookkeeping for one offered target.
    task automatic push_expect(input logic [W-1:0] t);
        exp_t e;
        e.tgt  = t;
        e.j0   = ~m_model & t;
        e.k0   = m_model & ~t;
        e.j1   = m_model ^ t;
        e.k1   = m_model ^ t;
        e.mask = t & stuck;
        m_err  = m_err | (|e.mask);
        m_cnt  = (m_cnt == 8'd255) ? 8'd255 : m_cnt + 8'd1;
        e.err  = m_err;
        e.cnt  = m_cnt;
        m_model = t;
        sb.push_back(e);
    endtask

    // One complete transfer, entered at a negedge; leaves off at the negedge of
    // the done cycle. keep=1 holds tgt_valid high for back-to-back operation.
    task automatic run_xfer(input logic [W-1:0] t, input bit keep);
        int   n;
        exp_t e;
        n = 0;
        while (!(rdy0 && rdy1) && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk1("ready_wait", rdy0 && rdy1, 1'b1);
        tgt_valid = 1'b1;
        tgt_data  = t;
        push_expect(t);
        @(posedge clk);
        #1;
        tgt_data = ~t;
        if (!keep) tgt_valid = 1'b0;
        @(negedge clk);
        e = sb[0];
        chk4("drive_j0", j0, e.j0);
        chk4("drive_k0", k0, e.k0);
        chk4("drive_j1", j1, e.j1);
        chk4("drive_k1", k1, e.k1);
        chk1("drive_ready", rdy0 | rdy1, 1'b0);
        chk1("drive_done", d0 | d1, 1'b0);
        @(negedge clk);
        chk4("check_jk", j0 | k0 | j1 | k1, '0);
        chk1("check_ready", rdy0 | rdy1, 1'b0);
        chk1("check_done", d0 | d1, 1'b0);
        @(negedge clk);
        e = sb.pop_front();
        chk1("done0", d0, 1'b1);
        chk1("done1", d1, 1'b1);
        chk4("bank_q0", q0, e.tgt);
        chk4("bank_q1", q1, e.tgt);
        chk4("err_mask0", em0, e.mask);
        chk4("err_mask1", em1, e.mask);
        chk1("err0", e0, e.err);
        chk1("err1", e1, e.err);
        chk8("count0", c0, e.cnt);
        chk8("count1", c1, e.cnt);
    endtask

    initial begin
        reset     = 1'b0;
        tgt_valid = 1'b1;
        tgt_data  = 4'b1111;
        stuck     = '0;
        m_model   = '0;
        m_err     = 1'b0;
        m_cnt     = 8'd0;

        // Reset held for two edges with a target offered.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk4("rst_jk", j0 | k0 | j1 | k1, '0);
        chk1("rst_ready", rdy0 | rdy1, 1'b0);
        chk1("rst_done", d0 | d1, 1'b0);
        chk1("rst_err", e0 | e1, 1'b0);
        chk4("rst_mask", em0 | em1, '0);
        chk8("rst_count", c0 | c1, 8'd0);
        tgt_valid = 1'b0;
        reset     = 1'b1;
        @(negedge clk);
        chk1("ready_after_rst", rdy0 && rdy1, 1'b1);

        // Basic set, then mixed transition 1010 -> 0110 on both DC modes.
        run_xfer(4'b1010, 1'b0);
        run_xfer(4'b0110, 1'b0);
        @(negedge clk);
        chk1("done_single", d0 | d1, 1'b0);

        // Stuck-at-0 feedback on bit 0, then a good transfer: err stays sticky.
        stuck = 4'b0001;
        run_xfer(4'b0001, 1'b0);
        stuck = 4'b0000;
        run_xfer(4'b0000, 1'b0);
        run_xfer(4'b1010, 1'b0);

        // Reset during DRIVE abandons the transfer.
        tgt_valid = 1'b1;
        tgt_data  = 4'b0101;
        @(posedge clk);
        #1;
        tgt_valid = 1'b0;
        @(negedge clk);
        chk4("pre_rst_drive_j0", j0, 4'b0101);
        reset = 1'b0;
        @(negedge clk);
        chk4("mid_rst_jk", j0 | k0 | j1 | k1, '0);
        chk1("mid_rst_done", d0 | d1, 1'b0);
        chk8("mid_rst_count", c0, 8'd0);
        chk1("mid_rst_err", e0, 1'b0);
        chk1("mid_rst_ready", rdy0, 1'b0);
        @(negedge clk);
        chk1("mid_rst_done2", d0 | d1, 1'b0);
        reset   = 1'b1;
        m_model = '0;
        m_err   = 1'b0;
        m_cnt   = 8'd0;
        sb.delete();

        // Back-to-back with tgt_valid held; includes a same-target transfer.
        run_xfer(4'b0011, 1'b1);
        run_xfer(4'b1100, 1'b1);
        run_xfer(4'b1111, 1'b1);
        run_xfer(4'b1111, 1'b0);

        // Saturation of the transfer counter.
        for (int i = 0; i < 256; i++) begin
            run_xfer(4'($urandom_range(0, 15)), 1'b0);
        end
        chk8("sat_count0", c0, 8'd255);
        chk8("sat_count1", c1, 8'd255);
        chk1("scoreboard_empty", sb.size() == 0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/jk_bank_driver.md
Name: jk_bank_driver

Overview:
- Drives the J/K inputs of an external bank of WIDTH JK flip-flops so the bank's q reaches a requested target word.
- Accepts target words over a valid/ready handshake and computes the per-bit excitation from the JK excitation table using an internal model of the bank's state.
- Drives J/K for exactly one clock, then checks the bank's q feedback against the target and reports any mismatched bits.
- It is the stimulus side of the JK register: it turns desired state transitions into J/K controls and checks that the register responded.

Parameters:
WIDTH, 4, number of JK flip-flops in the driven bank.
DC_MODE, 0, resolution of excitation-table don't-cares: 0 -> x resolves to 0; 1 -> x resolves to 1 (changing bits use toggle J=K=1).

Ports:
clk  input  1  system clock, all logic on rising edge.
reset  input  1  reset is synchronous and active-low.
tgt_valid  input  1  target word offered.
tgt_data  input  WIDTH  requested next q of bank.
tgt_ready  output  1  block can accept a target.
j  output  WIDTH  J inputs to bank.
k  output  WIDTH  K inputs to bank.
q_fb  input  WIDTH  q outputs of bank, fed back.
done  output  1  one-cycle pulse, transfer finished.
err  output  1  sticky, any check mismatch since reset.
err_mask  output  WIDTH  mismatched bits of the last completed transfer.
xfer_count  output  8  completed transfers, saturating.

Behaviour:
- Reset (reset=0 at a rising edge):
  - state=IDLE, model=0, j=0, k=0, done=0, err=0, err_mask=0, xfer_count=0.
  - tgt_ready=0 while reset=0.
  - Reset overrides every state. A transfer in flight is abandoned, with no done and no count increment.
- tgt_ready = (state==IDLE) && reset. It is combinational from the state register.
- FSM states are IDLE, DRIVE, CHECK.
  - IDLE: j=k=0. On tgt_valid && tgt_ready, latch tgt into target, register the excitation, then go to DRIVE.
  - DRIVE (exactly 1 cycle): j/k are held at the registered excitation. The bank samples them at the edge that ends DRIVE. Go to CHECK.
  - CHECK (exactly 1 cycle): j=k=0. Compare q_fb with target. At the closing edge:
    - err_mask <= q_fb ^ target.
    - err <= err | (|mask).
    - done <= 1.
    - model <= target.
    - xfer_count increments (holds at 255).
    - Go to IDLE.
- done is high for exactly one cycle, namely the first IDLE cycle after CHECK. A new target may be accepted in that same cycle.
- Throughput is one target per 3 cycles. Latency from the accept edge to done high is 3 edges.
- Per-bit excitation from model m to target t:
  - 0->0: J=0, K=DC_MODE&0 (always 0).
  - 0->1: J=1, K=DC_MODE.
  - 1->0: J=DC_MODE, K=1.
  - 1->1: J=0, K=0.
  - Hold cases always drive 0/0 so unchanged bits never toggle.
- target==model is still a full transfer: j=k=0 during DRIVE, then check, done and count as normal.
- err and err_mask change only in CHECK or on reset. err is cleared only by reset.
- The model tracks the commanded target, not q_fb. After a mismatch the next excitation is computed from target.
- tgt_data and tgt_valid are ignored outside IDLE. No buffering.

Test Plan:
- Reset: hold reset=0 for 2 edges with tgt_valid=1 -> j=k=0, tgt_ready=0, done=0, err=0, xfer_count=0. After release, tgt_ready=1 in the next cycle.
- Basic set, DC_MODE=0, behavioural JK bank attached: model 0000, offer 1010 -> DRIVE cycle shows j=1010, k=0000. Bank q=1010 in CHECK. done pulses once, err_mask=0000, err=0, xfer_count=1.
- Mixed transition: from 1010 offer 0110.
  - DC_MODE=0 -> j=0100, k=1000.
  - Repeat with DC_MODE=1 -> j=1100, k=1100.
  - In both cases final q=0110 and err=0.
- Fault: bench forces q_fb[0] stuck at 0, offer 0001 -> err_mask=0001, err=1. Next good transfer (0000) gives err_mask=0000 while err stays 1.
- Back-to-back: tgt_valid held 1 with 0011, 1100, 1111 -> accepts spaced 3 cycles apart. tgt_ready=0 in DRIVE and CHECK. 3 done pulses, xfer_count=3. 1100->1111 drives j=0011, k=0000. Same-target transfer (1111->1111) drives j=k=0000 and still counts.
- Reset mid-operation: assert reset=0 during DRIVE -> no done pulse, j=k=0 after that edge, model=0000, xfer_count=0. Then drive 256 transfers and check xfer_count saturates at 255.
